// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, 2-bit port number, 4-bit length (both MSB first),
// then the payload LSB first. Advances only on Clk_EN ticks; SerOut idles high.
module serial_frame_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        Clk_EN,
  input  logic        start,
  input  logic [1:0]  port_sel,
  input  logic [3:0]  len,
  input  logic [14:0] data_in,
  output logic        SerOut,
  output logic        busy,
  output logic        done,
  output logic [3:0]  bits_left,
  output logic [2:0]  state_dbg
);

  // Handshake: a request is taken on a tick edge where start=1 and busy=0;
  // busy stays high until the frame-ending tick, which also pulses done for one clk.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    PORT  = 3'd2,
    LEN   = 3'd3,
    DATA  = 3'd4
  } state_t;

  state_t      state;
  logic [1:0]  port_q;
  logic [3:0]  len_q;
  logic [14:0] shreg;
  logic [1:0]  pos;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      SerOut    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      bits_left <= 4'd0;
      port_q    <= 2'd0;
      len_q     <= 4'd0;
      shreg     <= 15'd0;
      pos       <= 2'd0;
    end else begin
      done <= 1'b0;
      if (Clk_EN) begin
        case (state)
          IDLE: begin
            if (start) begin
              port_q    <= port_sel;
              len_q     <= len;
              shreg     <= data_in;
              bits_left <= len;
              SerOut    <= 1'b0;
              busy      <= 1'b1;
              state     <= START;
            end
          end
          START: begin
            SerOut <= port_q[1];
            pos    <= 2'd1;
            state  <= PORT;
          end
          PORT: begin
            if (pos == 2'd1) begin
              SerOut <= port_q[0];
              pos    <= 2'd0;
            end else begin
              SerOut <= len_q[3];
              pos    <= 2'd3;
              state  <= LEN;
            end
          end
          LEN: begin
            // pos is the index of the length bit currently on the line
            if (pos != 2'd0) begin
              SerOut <= len_q[pos - 2'd1];
              pos    <= pos - 2'd1;
            end else if (len_q == 4'd0) begin
              SerOut    <= 1'b1;
              busy      <= 1'b0;
              done      <= 1'b1;
              bits_left <= 4'd0;
              state     <= IDLE;
            end else begin
              SerOut    <= shreg[0];
              shreg     <= {1'b0, shreg[14:1]};
              bits_left <= len_q - 4'd1;
              state     <= DATA;
            end
          end
          DATA: begin
            // bits_left reaches 0 while the last payload bit is on the line
            if (bits_left != 4'd0) begin
              SerOut    <= shreg[0];
              shreg     <= {1'b0, shreg[14:1]};
              bits_left <= bits_left - 4'd1;
            end else begin
              SerOut    <= 1'b1;
              busy      <= 1'b0;
              done      <= 1'b1;
              bits_left <= 4'd0;
              state     <= IDLE;
            end
          end
          default: begin
            SerOut    <= 1'b1;
            busy      <= 1'b0;
            bits_left <= 4'd0;
            state     <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: random frames pushed to an expected queue, a tick-level
// monitor decodes the line like the port-demux receiver and checks against the queue.
module tb_serial_frame_tx;

  logic        clk;
  logic        rst;
  logic        Clk_EN;
  logic        start;
  logic [1:0]  port_sel;
  logic [3:0]  len;
  logic [14:0] data_in;
  logic        SerOut;
  logic        busy;
  logic        done;
  logic [3:0]  bits_left;
  logic [2:0]  state_dbg;

  serial_frame_tx dut (
    .clk       (clk),
    .rst       (rst),
    .Clk_EN    (Clk_EN),
    .start     (start),
    .port_sel  (port_sel),
    .len       (len),
    .data_in   (data_in),
    .SerOut    (SerOut),
    .busy      (busy),
    .done      (done),
    .bits_left (bits_left),
    .state_dbg (state_dbg)
  );

  int          errors;
  int          checks;
  logic [20:0] exp_q[$];   // {port[1:0], len[3:0], data[14:0]}
  bit          gate;
  int          started_frames;
  bit          burst_mode;
  int          burst_frames;
  logic [14:0] rx_port_data [4];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // bit tick every 4 clks, suppressible by gate
  initial begin
    int c;
    c = 0;
    Clk_EN = 1'b0;
    forever begin
      @(negedge clk);
      c = (c + 1) % 4;
      Clk_EN = (c == 0) && !gate;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard
  initial begin
    bit          t;
    bit          r;
    bit          armed;
    bit          in_frame;
    int          idx;
    int          l;
    int          idle_ticks;
    int          exp_bl;
    logic        eb;
    logic [20:0] cur;
    logic [1:0]  rx_port;
    int          rx_len;
    logic        p_ser;
    logic        p_busy;
    logic [3:0]  p_bl;
    logic [14:0] mask;
    armed = 0; in_frame = 0; idx = 0; idle_ticks = 0; cur = '0;
    rx_port = 0; rx_len = 0; l = 0;
    p_ser = 1'b1; p_busy = 1'b0; p_bl = 4'd0;
    forever begin
      @(posedge clk);
      t = Clk_EN;
      r = rst;
      #1;
      if (r) begin
        armed = 1; in_frame = 0; idle_ticks = 0;
        exp_q.delete();
        chk("rst_serout", SerOut, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bits_left", bits_left, 0);
      end else if (armed && !t) begin
        chk("hold_serout", SerOut, p_ser);
        chk("hold_busy", busy, p_busy);
        chk("hold_bits_left", bits_left, p_bl);
        chk("hold_done", done, 0);
      end else if (armed && t) begin
        if (!in_frame) begin
          if (SerOut === 1'b0) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_frame", 1, 0);
              cur = '0;
            end else begin
              cur = exp_q.pop_front();
            end
            l = int'(cur[18:15]);
            chk("accept_busy", busy, 1);
            chk("accept_done", done, 0);
            chk("accept_bits_left", bits_left, l);
            if (burst_mode && burst_frames > 0)
              chk("idle_gap_ticks", idle_ticks + 1, 1);
            if (burst_mode) burst_frames++;
            started_frames++;
            in_frame = 1; idx = 0; rx_port = 0; rx_len = 0;
            for (int q = 0; q < 4; q++) rx_port_data[q] = '0;
          end else begin
            chk("idle_serout", SerOut, 1);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_bits_left", bits_left, 0);
            idle_ticks++;
          end
        end else begin
          idx++;
          if (idx < 7 + l) begin
            if (idx == 1)      eb = cur[20];
            else if (idx == 2) eb = cur[19];
            else if (idx <= 6) eb = cur[15 + (6 - idx)];
            else               eb = cur[idx - 7];
            exp_bl = (idx < 7) ? l : l - 1 - (idx - 7);
            chk("frame_bit", SerOut, eb);
            chk("frame_busy", busy, 1);
            chk("frame_done", done, 0);
            chk("frame_bits_left", bits_left, exp_bl);
            // receiver side: demux payload onto the port decoded from the line
            if (idx <= 2)      rx_port = {rx_port[0], SerOut};
            else if (idx <= 6) rx_len = rx_len * 2 + int'(SerOut);
            else               rx_port_data[rx_port][idx - 7] = SerOut;
          end else begin
            chk("end_serout", SerOut, 1);
            chk("end_busy", busy, 0);
            chk("end_done", done, 1);
            chk("end_bits_left", bits_left, 0);
            chk("rx_port", rx_port, cur[20:19]);
            chk("rx_len", rx_len, l);
            mask = 15'((32'd1 << l) - 32'd1);
            for (int q = 0; q < 4; q++)
              chk("rx_port_data", rx_port_data[q],
                  (q == int'(cur[20:19])) ? (cur[14:0] & mask) : 15'd0);
            in_frame = 0; idle_ticks = 0;
          end
        end
      end
      p_ser = SerOut; p_busy = busy; p_bl = bits_left;
    end
  end

  // driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (Clk_EN) k++;
    end
    #2;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while (busy !== 1'b0 && b < 400) begin
      wait_clks(1);
      b++;
    end
    if (b >= 400) chk("idle_timeout", 1, 0);
  endtask

  task automatic randomize_inputs();
    port_sel = 2'($urandom_range(0, 3));
    len      = 4'($urandom_range(0, 15));
    data_in  = 15'($urandom);
  endtask

  task automatic send(input logic [1:0] p, input logic [3:0] l, input logic [14:0] d);
    int b;
    wait_idle();
    port_sel = p; len = l; data_in = d; start = 1'b1;
    exp_q.push_back({p, l, d});
    b = 0;
    while (busy !== 1'b1 && b < 20) begin
      wait_clks(1);
      b++;
    end
    if (b >= 20) chk("accept_timeout", 1, 0);
    start = 1'b0;
    randomize_inputs();
  endtask

  // stimulus
  initial begin
    int s0;
    int b;
    errors = 0; checks = 0; gate = 0; started_frames = 0;
    burst_mode = 0; burst_frames = 0;
    rst = 1'b1; start = 1'b0; port_sel = '0; len = '0; data_in = '0;
    for (int q = 0; q < 4; q++) rx_port_data[q] = '0;
    wait_clks(6);
    rst = 1'b0;
    wait_clks(8);

    send(2'd2, 4'd3, 15'b101);
    send(2'd0, 4'd0, 15'd0);
    wait_idle();

    // start held high: back-to-back frames with one idle-high bit
    burst_mode = 1; burst_frames = 0;
    s0 = started_frames;
    repeat (3) exp_q.push_back({2'd1, 4'd1, 15'd1});
    port_sel = 2'd1; len = 4'd1; data_in = 15'd1; start = 1'b1;
    b = 0;
    while (started_frames < s0 + 3 && b < 200) begin
      wait_clks(1);
      b++;
    end
    if (b >= 200) chk("burst_timeout", 1, 0);
    start = 1'b0;
    wait_idle();
    burst_mode = 0;

    for (int p = 0; p < 4; p++) send(2'(p), 4'd15, 15'($urandom));

    // random frames; start pulsed while busy must be ignored
    for (int i = 0; i < 12; i++) begin
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 15'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        start = 1'b1;
        wait_clks(8);
        start = 1'b0;
      end
    end

    // Clk_EN gated for 20 clks mid-frame with inputs changing
    send(2'd3, 4'd10, 15'($urandom));
    wait_ticks(3);
    gate = 1;
    for (int i = 0; i < 4; i++) begin
      randomize_inputs();
      wait_clks(5);
    end
    gate = 0;

    // reset at tick 5 of a len=15 frame
    send(2'd1, 4'd15, 15'($urandom));
    wait_ticks(5);
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    wait_clks(12);
    send(2'd2, 4'd7, 15'($urandom));
    wait_idle();
    wait_clks(16);

    chk("pending_frames", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high; ports are named clk and rst.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 Clk_EN  input  1  one-clk-wide bit tick (One_Pulser output); the frame advances only on clk edges where Clk_EN=1.
REQ-005 start  input  1  frame request; sampled only on tick edges.
REQ-006 port_sel  input  2  destination port number, 0..3.
REQ-007 len  input  4  number of data bits to send, 0..15.
REQ-008 data_in  input  15  payload; bit 0 is sent first.
REQ-009 SerOut  output  1  registered serial line; idle level 1.
REQ-010 busy  output  1  high from the start-accept edge until the frame ends.
REQ-011 done  output  1  single-clk pulse at the end of a frame.
REQ-012 bits_left  output  4  registered count of payload bits still to send.

Function
REQ-013 States SHALL be IDLE, START, PORT, LEN, DATA; bit-position and payload counters SHALL change only on tick edges.
REQ-014 In IDLE on a tick with start=1, the block SHALL latch port_sel, len and data_in, go to START, drive SerOut=0 and set busy=1; all on the same edge.
REQ-015 Each later tick SHALL emit exactly one bit; SerOut SHALL be stable between ticks.
REQ-016 Frame order SHALL be: start bit 0; port number 2 bits MSB first; len 4 bits MSB first; then len payload bits, data_in[0] first.
REQ-017 Frame length SHALL be 7+len ticks, counted from the accept edge up to the return to idle.
REQ-018 In DATA, bits_left SHALL decrement by 1 per tick; bits_left SHALL equal len during START, PORT and LEN; it SHALL be 0 in IDLE.
REQ-019 With len=0, the block SHALL skip DATA and return to IDLE on the tick after the last LEN bit.
REQ-020 On the frame-ending tick, the block SHALL set SerOut=1, busy=0 and state=IDLE, and assert done for exactly that one clk cycle.
REQ-021 start SHALL be ignored while busy=1; it SHALL also be ignored on non-tick edges.
REQ-022 A start held high at the frame-ending tick SHALL NOT be accepted on that edge; it SHALL be accepted on the next tick, giving at least one idle-high bit between frames.
REQ-023 Changes to port_sel, len or data_in during a frame SHALL NOT affect the frame in progress.
REQ-024 With Clk_EN held 0, all state and outputs SHALL hold; done SHALL remain 0.
REQ-025 The transmitted frame SHALL be decodable by the team's serial port-demux receiver: bits land on the selected port output, and the receiver data counter reaches 0 after len bits.

Reset
REQ-026 On rst=1 at a clk edge, regardless of Clk_EN, the block SHALL apply: state=IDLE, SerOut=1, busy=0, done=0, bits_left=0, latched fields=0.
REQ-027 Reset mid-frame SHALL abort the frame at once; no done pulse SHALL be produced.
REQ-028 rst SHALL take priority over start and Clk_EN on the same edge.

Verification
REQ-029 Tick every 4 clks; port_sel=2, len=3, data_in=0b101, start -> SerOut per tick: 0,1,0,0,0,1,1,1,0,1, then 1; busy high 10 ticks; one done pulse.
REQ-030 port_sel=0, len=0, start -> SerOut 0,0,0,0,0,0,0 over 7 ticks, then idle 1; bits_left stays 0; done pulses after 7 ticks.
REQ-031 start held high continuously, len=1 -> frames separated by exactly one idle-high tick; busy low for that one tick only.
REQ-032 rst asserted at tick 5 of a len=15 frame -> next edge: SerOut=1, busy=0, bits_left=0, no done; a new start afterwards gives a correct frame.
REQ-033 data_in changed mid-frame and Clk_EN gated low for 20 clks -> SerOut and bits_left frozen during the gap; payload matches the value latched at accept.
REQ-034 Loopback into the receiver datapath, all 4 ports with len=15 and random payloads -> bits appear only on the selected port output; the receiver data counter reaches 0 on the last payload bit.
